// File: rtl/poly_unpacker.sv
// poly_unpacker: turns a 12-bit packed polynomial byte stream (3 bytes per
// coefficient pair) into indexed coefficient pairs for the accumulator,
// and paces each pair on the accumulator status. It also flags any
// coefficient that is not reduced modulo KYBER_Q.
module poly_unpacker #(
  parameter int KYBER_Q = 3329,
  parameter int NPAIRS  = 128,
  parameter int DW      = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          set,
  input  logic          start,
  input  logic [3:0]    cmd_in,
  input  logic [3:0]    acc_status,
  input  logic          byte_valid,
  input  logic [7:0]    byte_data,
  output logic          byte_ready,
  output logic [3:0]    cmd,
  output logic          readin,
  output logic [6:0]    addr_a,
  output logic [6:0]    addr_b,
  output logic [DW-1:0] data_a,
  output logic [DW-1:0] data_b,
  output logic          busy,
  output logic          done,
  output logic          range_err
);

  localparam logic [11:0] QMOD     = 12'(KYBER_Q);
  localparam logic [6:0]  LAST_IDX = 7'(NPAIRS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_B0,
    S_B1,
    S_B2,
    S_EMIT
  } state_t;

  state_t          state_q, state_d;
  logic [3:0]      cmd_q, cmd_d;
  logic [6:0]      cnt_q, cnt_d;
  logic [7:0]      b0_q, b0_d;
  logic [7:0]      b1_q, b1_d;
  logic [6:0]      addr_q, addr_d;
  logic [DW-1:0]   data_a_q, data_a_d;
  logic [DW-1:0]   data_b_q, data_b_d;
  logic            readin_q, readin_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            range_err_q, range_err_d;
  logic [11:0]     c0, c1;
  logic            byte_acc;

  // Next-state logic: byte collection, pair emission and handshake pacing.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no path leaves
    // it unassigned; an unassigned path would infer a latch.
    state_d     = state_q;
    cmd_d       = cmd_q;
    cnt_d       = cnt_q;
    b0_d        = b0_q;
    b1_d        = b1_q;
    addr_d      = addr_q;
    data_a_d    = data_a_q;
    data_b_d    = data_b_q;
    readin_d    = readin_q;
    busy_d      = busy_q;
    done_d      = done_q;
    range_err_d = range_err_q;
    byte_ready  = 1'b0;
    // The third byte completes the pair: low nibble of b1 tops c0, high
    // nibble of b1 is the bottom of c1.
    c0          = {b1_q[3:0], b0_q};
    c1          = {byte_data, b1_q[7:4]};
    byte_acc    = 1'b0;

    // With set low everything holds, including the done pulse.
    if (set) begin
      done_d     = 1'b0;
      byte_ready = (state_q == S_B0) || (state_q == S_B1) || (state_q == S_B2);
      byte_acc   = byte_ready && byte_valid;

      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            cmd_d       = cmd_in;
            cnt_d       = '0;
            range_err_d = 1'b0;
            busy_d      = 1'b1;
            state_d     = S_B0;
          end
        end
        S_B0: begin
          if (byte_acc) begin
            b0_d    = byte_data;
            state_d = S_B1;
          end
        end
        S_B1: begin
          if (byte_acc) begin
            b1_d    = byte_data;
            state_d = S_B2;
          end
        end
        S_B2: begin
          if (byte_acc) begin
            data_a_d    = {{(DW-12){1'b0}}, c0};
            data_b_d    = {{(DW-12){1'b0}}, c1};
            addr_d      = cnt_q;
            readin_d    = 1'b1;
            range_err_d = range_err_q | (c0 >= QMOD) | (c1 >= QMOD);
            state_d     = S_EMIT;
          end
        end
        S_EMIT: begin
          if (acc_status == cmd_q) begin
            readin_d = 1'b0;
            if (cnt_q == LAST_IDX) begin
              done_d  = 1'b1;
              busy_d  = 1'b0;
              state_d = S_IDLE;
            end else begin
              cnt_d   = cnt_q + 7'd1;
              state_d = S_B0;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State register; reset aborts any polynomial in flight immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cmd_q       <= '0;
      cnt_q       <= '0;
      b0_q        <= '0;
      b1_q        <= '0;
      addr_q      <= '0;
      data_a_q    <= '0;
      data_b_q    <= '0;
      readin_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      range_err_q <= 1'b0;
    end else begin
      // NOTE: non-blocking updates so every register samples the pre-edge
      // value of every other register.
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      cnt_q       <= cnt_d;
      b0_q        <= b0_d;
      b1_q        <= b1_d;
      addr_q      <= addr_d;
      data_a_q    <= data_a_d;
      data_b_q    <= data_b_d;
      readin_q    <= readin_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      range_err_q <= range_err_d;
    end
  end

  assign cmd       = cmd_q;
  assign readin    = readin_q;
  assign addr_a    = addr_q;
  assign addr_b    = addr_q;
  assign data_a    = data_a_q;
  assign data_b    = data_b_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign range_err = range_err_q;

endmodule

// File: tb/tb_poly_unpacker.sv
// Bench for poly_unpacker: table-driven first-pair vectors, hand-written
// stall/reset/freeze sequences, and full random polynomials compared with a
// coefficient-level reference model.
module tb_poly_unpacker;

  localparam int Q  = 3329;
  localparam int NP = 128;

  logic        clk = 1'b0;
  logic        reset, set, start;
  logic [3:0]  cmd_in, acc_status;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic [3:0]  cmd;
  logic        readin;
  logic [6:0]  addr_a, addr_b;
  logic [15:0] data_a, data_b;
  logic        busy, done, range_err;

  poly_unpacker dut (
    .clk        (clk),
    .reset      (reset),
    .set        (set),
    .start      (start),
    .cmd_in     (cmd_in),
    .acc_status (acc_status),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .cmd        (cmd),
    .readin     (readin),
    .addr_a     (addr_a),
    .addr_b     (addr_b),
    .data_a     (data_a),
    .data_b     (data_b),
    .busy       (busy),
    .done       (done),
    .range_err  (range_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: the polynomial as plain integers, plus its byte image.
  int coef   [256];
  int stream [384];

  int pair_idx = 0;
  int done_cnt = 0;
  bit mon_en   = 1'b0;

  typedef struct {
    logic [7:0]  b0, b1, b2;
    logic [15:0] exp_a, exp_b;
    logic        exp_err;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Pack coefficients into the 3-bytes-per-pair little-endian 12-bit image.
  task automatic pack_poly();
    for (int p = 0; p < NP; p++) begin
      int a, b;
      a = coef[2*p];
      b = coef[2*p+1];
      stream[3*p]   = a % 256;
      stream[3*p+1] = a / 256 + 16 * (b % 16);
      stream[3*p+2] = b / 16;
    end
  endtask

  task automatic gen_poly(input bit allow_big);
    for (int i = 0; i < 256; i++)
      coef[i] = allow_big ? int'($urandom_range(0, 4095)) : int'($urandom_range(0, Q - 1));
    pack_poly();
  endtask

  function automatic bit model_err();
    bit e = 1'b0;
    for (int i = 0; i < 256; i++) if (coef[i] >= Q) e = 1'b1;
    return e;
  endfunction

  // Accumulator-side monitor: each accepted pair must match the model in order.
  always @(negedge clk) begin
    if (mon_en) begin
      if (readin) check("ready_low_in_emit", {31'd0, byte_ready}, 32'd0);
      if (readin && set && acc_status == cmd) begin
        check("pair_addr_a", {25'd0, addr_a}, pair_idx);
        check("pair_addr_b", {25'd0, addr_b}, pair_idx);
        check("pair_data_a", {16'd0, data_a}, coef[(2*pair_idx) % 256]);
        check("pair_data_b", {16'd0, data_b}, coef[(2*pair_idx+1) % 256]);
        pair_idx++;
      end
      if (done) done_cnt++;
    end
  end

  task automatic pulse_reset();
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
  endtask

  task automatic do_start(input logic [3:0] c);
    @(posedge clk); #1 start = 1'b1; cmd_in = c;
    @(posedge clk); #1 start = 1'b0;
  endtask

  // Offer stream[first..first+n-1]; a byte counts only when valid and ready.
  task automatic feed_bytes(input int first, input int n, input bit rnd);
    int k = 0;
    int guard = 0;
    while (k < n && guard < 20000) begin
      @(posedge clk); #1;
      byte_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      byte_data  = 8'(stream[first + k]);
      @(negedge clk);
      if (byte_valid && byte_ready) k++;
      guard++;
    end
    @(posedge clk); #1 byte_valid = 1'b0;
    if (k < n) check("feed_timeout", k, n);
  endtask

  task automatic wait_done();
    int g = 0;
    while (done_cnt == 0 && g < 3000) begin
      @(negedge clk);
      g++;
    end
    check("done_seen", done_cnt, 1);
    repeat (3) @(negedge clk);
    check("done_once", done_cnt, 1);
    check("pairs_total", pair_idx, NP);
    check("busy_after_done", {31'd0, busy}, 32'd0);
    check("readin_after_done", {31'd0, readin}, 32'd0);
  endtask

  // One whole polynomial with optional random valid gaps and a set freeze.
  task automatic run_full(input logic [3:0] c, input bit rnd, input bit freeze);
    bit exp_err;
    exp_err  = model_err();
    pair_idx = 0;
    done_cnt = 0;
    mon_en   = 1'b1;
    acc_status = c;
    do_start(c);
    @(negedge clk);
    check("busy_after_start", {31'd0, busy}, 32'd1);
    if (freeze) begin
      fork
        feed_bytes(0, 384, rnd);
        begin
          logic [6:0] a_hold;
          int         p_hold;
          repeat (150) @(posedge clk);
          #1 set = 1'b0;
          @(negedge clk);
          a_hold = addr_a;
          p_hold = pair_idx;
          repeat (5) begin
            check("ready_low_frozen", {31'd0, byte_ready}, 32'd0);
            @(negedge clk);
          end
          check("addr_frozen", {25'd0, addr_a}, {25'd0, a_hold});
          check("no_pair_frozen", pair_idx, p_hold);
          @(posedge clk); #1 set = 1'b1;
        end
      join
    end else begin
      feed_bytes(0, 384, rnd);
    end
    wait_done();
    check("range_err_final", {31'd0, range_err}, {31'd0, exp_err});
    check("cmd_held", {28'd0, cmd}, {28'd0, c});
    mon_en = 1'b0;
  endtask

  vec_t vecs [6];

  initial begin
    vecs[0] = '{8'h01, 8'h23, 8'h45, 16'h0301, 16'h0452, 1'b0};
    vecs[1] = '{8'h01, 8'hD0, 8'hFF, 16'h0001, 16'h0FFD, 1'b1};
    vecs[2] = '{8'h00, 8'h0D, 8'hD0, 16'h0D00, 16'h0D00, 1'b0};
    vecs[3] = '{8'h01, 8'h0D, 8'h00, 16'h0D01, 16'h0000, 1'b1};
    vecs[4] = '{8'hFF, 8'h0C, 8'hD0, 16'h0CFF, 16'h0D00, 1'b0};
    vecs[5] = '{8'hFF, 8'hFF, 8'hFF, 16'h0FFF, 16'h0FFF, 1'b1};

    reset = 1'b1; set = 1'b1; start = 1'b0; cmd_in = '0; acc_status = '0;
    byte_valid = 1'b0; byte_data = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_readin", {31'd0, readin}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_cmd", {28'd0, cmd}, 32'd0);
    check("rst_addr", {25'd0, addr_a}, 32'd0);
    check("rst_range_err", {31'd0, range_err}, 32'd0);
    check("rst_byte_ready", {31'd0, byte_ready}, 32'd0);

    // First-pair vectors: feed 3 bytes, hold the pair in EMIT, inspect it.
    for (int v = 0; v < 6; v++) begin
      pulse_reset();
      acc_status = 4'd0;
      do_start(4'd1);
      stream[0] = vecs[v].b0;
      stream[1] = vecs[v].b1;
      stream[2] = vecs[v].b2;
      feed_bytes(0, 3, 1'b0);
      @(negedge clk);
      check("vec_readin", {31'd0, readin}, 32'd1);
      check("vec_data_a", {16'd0, data_a}, {16'd0, vecs[v].exp_a});
      check("vec_data_b", {16'd0, data_b}, {16'd0, vecs[v].exp_b});
      check("vec_addr", {25'd0, addr_a}, 32'd0);
      check("vec_range_err", {31'd0, range_err}, {31'd0, vecs[v].exp_err});
      acc_status = 4'd1;
      @(negedge clk);
      check("vec_readin_one_cycle", {31'd0, readin}, 32'd0);
    end
    pulse_reset();

    // Reset while pair 40 sits in EMIT, then a clean full run.
    gen_poly(1'b0);
    pair_idx = 0; done_cnt = 0; mon_en = 1'b1;
    acc_status = 4'd1;
    do_start(4'd1);
    feed_bytes(0, 120, 1'b0);
    @(negedge clk);
    @(posedge clk); #1 acc_status = 4'd0;
    feed_bytes(120, 3, 1'b0);
    @(negedge clk);
    check("t1_pair40_emit", {31'd0, readin}, 32'd1);
    check("t1_pair40_addr", {25'd0, addr_a}, 32'd40);
    check("t1_pairs_before", pair_idx, 40);
    @(posedge clk); #2 reset = 1'b1;
    #1;
    check("t1_rst_readin", {31'd0, readin}, 32'd0);
    check("t1_rst_busy", {31'd0, busy}, 32'd0);
    check("t1_rst_addr", {25'd0, addr_a}, 32'd0);
    check("t1_rst_cmd", {28'd0, cmd}, 32'd0);
    mon_en = 1'b0;
    @(negedge clk); reset = 1'b0;
    run_full(4'd1, 1'b0, 1'b0);

    // Full stream with a non-trivial command value.
    gen_poly(1'b0);
    run_full(4'd5, 1'b0, 1'b0);

    // Ten-cycle stall on pair 5, then continue to completion.
    gen_poly(1'b0);
    pair_idx = 0; done_cnt = 0; mon_en = 1'b1;
    acc_status = 4'd1;
    do_start(4'd1);
    feed_bytes(0, 15, 1'b0);
    @(negedge clk);
    @(posedge clk); #1 acc_status = 4'd0;
    feed_bytes(15, 3, 1'b0);
    repeat (10) begin
      @(negedge clk);
      check("t4_readin_stall", {31'd0, readin}, 32'd1);
      check("t4_addr_stall", {25'd0, addr_a}, 32'd5);
      check("t4_data_a_stall", {16'd0, data_a}, coef[10]);
      check("t4_data_b_stall", {16'd0, data_b}, coef[11]);
      check("t4_ready_stall", {31'd0, byte_ready}, 32'd0);
    end
    check("t4_pairs_stall", pair_idx, 5);
    @(posedge clk); #1 acc_status = 4'd1;
    feed_bytes(18, 366, 1'b0);
    wait_done();
    mon_en = 1'b0;

    // Out-of-range pair at index 0: range_err sticks through done, start clears it.
    gen_poly(1'b0);
    coef[0] = 1;
    coef[1] = 4093;
    pack_poly();
    run_full(4'd1, 1'b0, 1'b0);
    check("t5_range_err_kept", {31'd0, range_err}, 32'd1);
    do_start(4'd1);
    @(negedge clk);
    check("t5_range_err_cleared", {31'd0, range_err}, 32'd0);
    pulse_reset();

    // Random valid gaps, a 5-cycle set freeze, and random 12-bit values.
    gen_poly(1'b0);
    run_full(4'd1, 1'b1, 1'b1);
    gen_poly(1'b1);
    run_full(4'd3, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
